// File: rtl/draw_pkg.sv
// Shared definitions for the shape rasterisers: engine state encoding and error-term sizing.
package draw_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StDraw,
    StDone
  } draw_state_e;

  // Headroom bits on top of the coordinate width for dx/dy/err terms.
  localparam int unsigned ErrMargin = 2;

  function automatic int unsigned err_width(input int unsigned cordw);
    return cordw + ErrMargin;
  endfunction

endpackage

// File: rtl/draw_line_engine.sv
// Bresenham line rasteriser: takes one line command and emits one framebuffer pixel write per
// non-stalled cycle, stepping from (x0,y0) to (x1,y1) inclusive without clipping.
module draw_line_engine
  import draw_pkg::*;
#(
  parameter int unsigned CORDW = 16,
  parameter int unsigned CIDXW = 4
) (
  input  logic                    clk_sys,
  input  logic                    rst_sys_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic signed [CORDW-1:0] x0,
  input  logic signed [CORDW-1:0] y0,
  input  logic signed [CORDW-1:0] x1,
  input  logic signed [CORDW-1:0] y1,
  input  logic        [CIDXW-1:0] cmd_cidx,
  input  logic                    fb_busy,
  output logic                    we,
  output logic signed [CORDW-1:0] x,
  output logic signed [CORDW-1:0] y,
  output logic        [CIDXW-1:0] cidx,
  output logic                    drawing,
  output logic                    done
);

  localparam int unsigned ErrW = err_width(CORDW);
  // e2 gets one extra bit so doubling err cannot wrap at full-range endpoints.
  localparam int unsigned E2W = ErrW + 1;

  typedef logic signed [CORDW-1:0] cord_t;
  typedef logic signed [ErrW-1:0]  err_t;
  typedef logic signed [E2W-1:0]   e2_t;

  draw_state_e state_q, state_d;

  cord_t            px_q, px_d, py_q, py_d;
  cord_t            ex_q, ex_d, ey_q, ey_d;
  err_t             dx_q, dx_d, dy_q, dy_d, err_q, err_d;
  logic             sx_q, sx_d, sy_q, sy_d;
  logic [CIDXW-1:0] col_q, col_d;

  logic             we_q, we_d;
  cord_t            xo_q, xo_d, yo_q, yo_d;
  logic [CIDXW-1:0] co_q, co_d;
  logic             done_q, done_d;

  err_t diff_x, diff_y;
  e2_t  e2;
  logic step_x, step_y, at_end;

  always_comb begin
    diff_x = err_t'(ex_q) - err_t'(px_q);
    diff_y = err_t'(ey_q) - err_t'(py_q);
    e2     = e2_t'(err_q) <<< 1;
    step_x = e2 >= e2_t'(dy_q);
    step_y = e2 <= e2_t'(dx_q);
    at_end = (px_q == ex_q) && (py_q == ey_q);
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    ex_d    = ex_q;
    ey_d    = ey_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    err_d   = err_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    col_d   = col_q;
    we_d    = 1'b0;
    xo_d    = xo_q;
    yo_d    = yo_q;
    co_d    = co_q;
    done_d  = (state_q == StDone);

    case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          px_d    = x0;
          py_d    = y0;
          ex_d    = x1;
          ey_d    = y1;
          col_d   = cmd_cidx;
          state_d = StInit;
        end
      end
      StInit: begin
        dx_d    = diff_x[ErrW-1] ? -diff_x : diff_x;
        dy_d    = diff_y[ErrW-1] ? diff_y : -diff_y;
        sx_d    = px_q < ex_q;
        sy_d    = py_q < ey_q;
        err_d   = dx_d + dy_d;
        state_d = StDraw;
      end
      StDraw: begin
        if (!fb_busy) begin
          we_d = 1'b1;
          xo_d = px_q;
          yo_d = py_q;
          co_d = col_q;
          if (at_end) begin
            state_d = StDone;
          end else begin
            // Both axis decisions come from the pre-update err via e2.
            if (step_x) begin
              err_d = err_d + dy_q;
              px_d  = sx_q ? px_q + cord_t'(1) : px_q - cord_t'(1);
            end
            if (step_y) begin
              err_d = err_d + dx_q;
              py_d  = sy_q ? py_q + cord_t'(1) : py_q - cord_t'(1);
            end
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q <= StIdle;
      px_q    <= '0;
      py_q    <= '0;
      ex_q    <= '0;
      ey_q    <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
      err_q   <= '0;
      sx_q    <= 1'b0;
      sy_q    <= 1'b0;
      col_q   <= '0;
      we_q    <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      co_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      ex_q    <= ex_d;
      ey_q    <= ey_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      err_q   <= err_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      col_q   <= col_d;
      we_q    <= we_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      co_q    <= co_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign drawing   = (state_q == StInit) || (state_q == StDraw);
  assign we        = we_q;
  assign x         = xo_q;
  assign y         = yo_q;
  assign cidx      = co_q;
  assign done      = done_q;

endmodule
